// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_rr_arbiter : round-robin Wishbone arbiter, NM masters onto one slave,   |
// |                 whole-cycle grants, owner-only responses, stall watchdog.  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module wb_rr_arbiter #(
    parameter int NM      = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic [NM-1:0]          i_m_cyc,
    input  logic [NM-1:0]          i_m_stb,
    input  logic [NM-1:0]          i_m_we,
    input  logic [NM*AW-1:0]       i_m_adr,
    input  logic [NM*DW-1:0]       i_m_dat,
    input  logic [NM*(DW/8)-1:0]   i_m_sel,
    output logic [NM-1:0]          o_m_ack,
    output logic [NM-1:0]          o_m_err,
    output logic [DW-1:0]          o_m_dat,
    output logic                   o_s_cyc,
    output logic                   o_s_stb,
    output logic                   o_s_we,
    output logic [AW-1:0]          o_s_adr,
    output logic [DW-1:0]          o_s_dat,
    output logic [DW/8-1:0]        o_s_sel,
    input  logic                   i_s_ack,
    input  logic                   i_s_err,
    input  logic [DW-1:0]          i_s_dat,
    output logic [NM-1:0]          o_grant,
    output logic                   o_timeout
);

    localparam int IW = $clog2(NM);
    localparam int SW = DW / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OWNED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q,  last_d;
    logic [CW-1:0]   wd_q,    wd_d;

    logic [IW-1:0]   w_pick;
    logic            w_found;
    logic [IW-1:0]   w_cand;
    logic            w_own_cyc;
    logic            w_own_stb;
    logic            w_fire;

    // Rotating scan starting just after the last owner.
    always_comb begin
        w_pick  = last_q;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= NM; k++) begin
            w_cand = IW'((int'(last_q) + k) % NM);
            if (!w_found && i_m_cyc[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    assign w_own_cyc = i_m_cyc[owner_q];
    assign w_own_stb = i_m_stb[owner_q];
    assign w_fire    = (TIMEOUT != 0) && (state_q == S_OWNED) && (wd_q == TMO);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= IW'(NM - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wd_d    = wd_q;
        case (state_q)
            S_IDLE: begin
                wd_d = '0;
                if (w_found) begin
                    state_d = S_OWNED;
                    owner_d = w_pick;
                end
            end
            S_OWNED: begin
                if (!w_own_cyc) begin
                    state_d = S_IDLE;
                    last_d  = owner_q;
                    wd_d    = '0;
                end else if (TIMEOUT == 0 || w_fire || i_s_ack || i_s_err || !w_own_stb) begin
                    wd_d = '0;
                end else begin
                    wd_d = wd_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Slave side is a pure mux on the registered owner; responses route back combinationally.
    always_comb begin
        o_grant   = '0;
        o_m_ack   = '0;
        o_m_err   = '0;
        o_m_dat   = '0;
        o_s_cyc   = 1'b0;
        o_s_stb   = 1'b0;
        o_s_we    = 1'b0;
        o_s_adr   = '0;
        o_s_dat   = '0;
        o_s_sel   = '0;
        o_timeout = 1'b0;
        if (state_q == S_OWNED) begin
            o_grant[owner_q] = 1'b1;
            o_s_cyc          = w_own_cyc;
            o_s_stb          = w_own_stb && !w_fire;
            o_s_we           = i_m_we[owner_q];
            o_s_adr          = i_m_adr[int'(owner_q)*AW +: AW];
            o_s_dat          = i_m_dat[int'(owner_q)*DW +: DW];
            o_s_sel          = i_m_sel[int'(owner_q)*SW +: SW];
            o_m_ack[owner_q] = i_s_ack && !w_fire;
            o_m_err[owner_q] = i_s_err || w_fire;
            o_m_dat          = (i_s_ack && !w_fire) ? i_s_dat : '0;
            o_timeout        = w_fire;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wb_rr_arbiter : scoreboard bench for wb_rr_arbiter                     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_wb_rr_arbiter;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic              i_clk;
    logic              i_rstn;
    logic [NM-1:0]     m_cyc, m_stb, m_we;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*DW-1:0]  m_dat;
    logic [NM*SW-1:0]  m_sel;
    logic              s_ack, s_err;
    logic [DW-1:0]     s_dat;

    logic [NM-1:0]     d_ack, d_err, d_grant;
    logic [DW-1:0]     d_mdat, d_sdat;
    logic              d_cyc, d_stb, d_we, d_tmo;
    logic [AW-1:0]     d_adr;
    logic [SW-1:0]     d_sel;

    logic [NM-1:0]     z_ack, z_err, z_grant;
    logic [DW-1:0]     z_mdat, z_sdat;
    logic              z_cyc, z_stb, z_we, z_tmo;
    logic [AW-1:0]     z_adr;
    logic [SW-1:0]     z_sel;

    wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) u_dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
        .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel),
        .o_m_ack(d_ack), .o_m_err(d_err), .o_m_dat(d_mdat),
        .o_s_cyc(d_cyc), .o_s_stb(d_stb), .o_s_we(d_we),
        .o_s_adr(d_adr), .o_s_dat(d_sdat), .o_s_sel(d_sel),
        .i_s_ack(s_ack), .i_s_err(s_err), .i_s_dat(s_dat),
        .o_grant(d_grant), .o_timeout(d_tmo)
    );

    // Watchdog-disabled twin: ownership must match, timeout must never fire.
    wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(0)) u_dut0 (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
        .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel),
        .o_m_ack(z_ack), .o_m_err(z_err), .o_m_dat(z_mdat),
        .o_s_cyc(z_cyc), .o_s_stb(z_stb), .o_s_we(z_we),
        .o_s_adr(z_adr), .o_s_dat(z_sdat), .o_s_sel(z_sel),
        .i_s_ack(s_ack), .i_s_err(s_err), .i_s_dat(s_dat),
        .o_grant(z_grant), .o_timeout(z_tmo)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [NM-1:0] grant;
        logic [NM-1:0] ack;
        logic [NM-1:0] err;
        logic [DW-1:0] rdat;
        logic          s_cyc;
        logic          s_stb;
        logic          s_we;
        logic [AW-1:0] adr;
        logic [DW-1:0] wdat;
        logic [SW-1:0] sel;
        logic          tmo;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: owner (-1 = nobody), last owner, consecutive stalled cycles.
    int own   = -1;
    int last  = NM - 1;
    int stall = 0;

    function automatic exp_t predict();
        exp_t e;
        bit   fire;
        e = '0;
        if (i_rstn && own >= 0) begin
            fire        = (stall == TO);
            e.grant[own] = 1'b1;
            e.s_cyc     = m_cyc[own];
            e.s_stb     = m_stb[own] && !fire;
            e.s_we      = m_we[own];
            e.adr       = m_adr[own*AW +: AW];
            e.wdat      = m_dat[own*DW +: DW];
            e.sel       = m_sel[own*SW +: SW];
            if (s_ack && !fire) begin
                e.ack[own] = 1'b1;
                e.rdat     = s_dat;
            end
            if (s_err || fire) e.err[own] = 1'b1;
            e.tmo = fire;
        end
        return e;
    endfunction

    task automatic advance();
        if (!i_rstn) begin
            own = -1; last = NM - 1; stall = 0;
        end else if (own < 0) begin
            stall = 0;
            for (int k = 1; k <= NM; k++) begin
                int c;
                c = (last + k) % NM;
                if (m_cyc[c]) begin
                    own = c;
                    break;
                end
            end
        end else if (!m_cyc[own]) begin
            last = own; own = -1; stall = 0;
        end else if (stall == TO || s_ack || s_err || !m_stb[own]) begin
            stall = 0;
        end else begin
            stall++;
        end
    endtask

    // Inputs for the current cycle are already applied: record expectation, step model, move on.
    task automatic cycle();
        exp_t e;
        if (!i_rstn) begin
            own = -1; last = NM - 1; stall = 0;
        end
        e = predict();
        q.push_back(e);
        last_exp = e;
        advance();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, a, x, $time);
        end
    endtask

    always @(negedge i_clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("grant",    64'(d_grant), 64'(mon_e.grant));
            chk("m_ack",    64'(d_ack),   64'(mon_e.ack));
            chk("m_err",    64'(d_err),   64'(mon_e.err));
            chk("m_dat",    64'(d_mdat),  64'(mon_e.rdat));
            chk("s_cyc",    64'(d_cyc),   64'(mon_e.s_cyc));
            chk("s_stb",    64'(d_stb),   64'(mon_e.s_stb));
            chk("s_we",     64'(d_we),    64'(mon_e.s_we));
            chk("s_adr",    64'(d_adr),   64'(mon_e.adr));
            chk("s_dat",    64'(d_sdat),  64'(mon_e.wdat));
            chk("s_sel",    64'(d_sel),   64'(mon_e.sel));
            chk("timeout",  64'(d_tmo),   64'(mon_e.tmo));
            chk("t0_grant", 64'(z_grant), 64'(mon_e.grant));
            chk("t0_tmo",   64'(z_tmo),   64'd0);
        end
    end

    task automatic clr_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0;
        m_adr = '0; m_dat = '0; m_sel = '0;
        s_ack = 1'b0; s_err = 1'b0; s_dat = '0;
    endtask

    int beats  [NM];
    int wait_c [NM];
    int stall_left;

    initial begin
        i_rstn = 1'b0;
        clr_inputs();
        @(posedge i_clk);
        #1;
        repeat (3) cycle();
        i_rstn = 1'b1;
        repeat (2) cycle();

        // Single request from master 2, acked two cycles after grant.
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_adr[2*AW +: AW] = 32'h1000; m_sel[2*SW +: SW] = 4'hF;
        cycle();
        cycle();
        cycle();
        s_ack = 1'b1; s_dat = 32'hCAFE_0002;
        cycle();
        s_ack = 1'b0; m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
        repeat (2) cycle();

        // Non-owner isolation: master 1 owns, master 3 waits through three acks.
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1*AW +: AW] = 32'h2000;
        cycle();
        m_cyc[3] = 1'b1; m_stb[3] = 1'b1; m_adr[3*AW +: AW] = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            s_ack = 1'b1; s_dat = 32'h1111_0000 + 32'(i);
            cycle();
            s_ack = 1'b0;
            cycle();
        end
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        repeat (3) cycle();
        s_ack = 1'b1; s_dat = 32'h3333_3333;
        cycle();
        s_ack = 1'b0; m_cyc[3] = 1'b0; m_stb[3] = 1'b0;
        repeat (2) cycle();

        // Watchdog: stalled strobe, two firings five cycles apart.
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 1'b1;
        repeat (14) cycle();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        repeat (2) cycle();

        // Reset mid-write while master 1 owns, then masters 0 and 3 collide.
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1; m_dat[1*DW +: DW] = 32'hDEAD_BEEF;
        repeat (3) cycle();
        i_rstn = 1'b0;
        repeat (2) cycle();
        i_rstn = 1'b1;
        clr_inputs();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[3] = 1'b1; m_stb[3] = 1'b1;
        cycle();
        cycle();
        s_ack = 1'b1; s_dat = 32'h0000_0A0A;
        cycle();
        s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        repeat (3) cycle();
        clr_inputs();
        repeat (2) cycle();

        // Randomized traffic: masters run bursts of 1..8 beats, slave acks randomly with stall windows.
        for (int k = 0; k < NM; k++) begin
            beats[k]  = 0;
            wait_c[k] = $urandom_range(3);
        end
        stall_left = 0;
        for (int n = 0; n < 3000; n++) begin
            exp_t pe;
            for (int k = 0; k < NM; k++) begin
                if (m_cyc[k]) begin
                    m_stb[k] = ($urandom_range(3) != 0);
                    m_we[k]  = 1'($urandom_range(1));
                    m_adr[k*AW +: AW] = $urandom;
                    m_dat[k*DW +: DW] = $urandom;
                    m_sel[k*SW +: SW] = 4'($urandom);
                end
            end
            if (stall_left == 0 && $urandom_range(199) == 0) stall_left = 15;
            s_ack = 1'b0; s_err = 1'b0; s_dat = $urandom;
            pe = predict();
            if (stall_left > 0) begin
                stall_left--;
            end else if (pe.s_stb) begin
                s_ack = ($urandom_range(99) < 45);
                s_err = !s_ack && ($urandom_range(99) < 4);
            end
            cycle();
            for (int k = 0; k < NM; k++) begin
                if (m_cyc[k]) begin
                    if (last_exp.ack[k] || last_exp.err[k]) beats[k]--;
                    if (beats[k] <= 0) begin
                        m_cyc[k]  = 1'b0;
                        m_stb[k]  = 1'b0;
                        wait_c[k] = $urandom_range(4);
                    end
                end else if (wait_c[k] == 0) begin
                    m_cyc[k] = 1'b1;
                    beats[k] = $urandom_range(8, 1);
                end else begin
                    wait_c[k]--;
                end
            end
        end
        clr_inputs();
        repeat (4) cycle();

        @(negedge i_clk);
        @(negedge i_clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
